// File: rtl/dmem_arb.sv
// dmem_arb: two-requester round-robin arbiter in front of a single data memory.
// Each granted request runs IDLE -> ACCESS -> RESP and completes with a
// one-cycle rvalid pulse on the port that was granted.
// Optional feature: define DMEM_ARB_MISALIGN_CHK_EN to treat misaligned
// halfword/word accesses as errors instead of passing them to memory.

module dmem_arb #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [2:0]  r0_funct3,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic        r0_err,
  output logic [31:0] r0_rdata,

  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [2:0]  r1_funct3,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic        r1_err,
  output logic [31:0] r1_rdata,

  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_funct3,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state;
  state_t      state_next;

  // Port granted most recently; resets to 1 so port 0 wins the first tie.
  logic        last_gnt;

  logic        gnt0;
  logic        gnt1;
  logic        any_gnt;

  // Fields of the port being granted this cycle.
  logic        cur_we;
  logic [2:0]  cur_funct3;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_err;

  // Transaction captured at the grant edge.
  logic        lat_port;
  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_err;

  // Response captured at the end of ACCESS.
  logic [31:0] resp_rdata;
  logic        resp_err;

  // Byte count of an access from the low funct3 bits (00=byte, 01=half, else word).
  function automatic logic [2:0] access_size(input logic [1:0] size_code);
    logic [2:0] bytes;
    case (size_code)
      2'b00:   bytes = 3'd1;
      2'b01:   bytes = 3'd2;
      default: bytes = 3'd4;
    endcase
    return bytes;
  endfunction

  // A request is rejected for an illegal funct3, a store with an unsigned
  // (1xx) width, an access running past the end of memory, or, when the
  // alignment check is built in, a misaligned halfword/word.
  function automatic logic access_error(input logic        we,
                                        input logic [2:0]  funct3,
                                        input logic [31:0] addr);
    logic        bad_funct3;
    logic        bad_store;
    logic        out_of_range;
    logic        misaligned;
    logic [32:0] end_addr;
    bad_funct3   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    bad_store    = we && funct3[2];
    end_addr     = {1'b0, addr} + {30'b0, access_size(funct3[1:0])};
    out_of_range = end_addr > MEM_LIMIT;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
    misaligned   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    misaligned   = 1'b0;
`endif
    return bad_funct3 || bad_store || out_of_range || misaligned;
  endfunction

  // Round-robin grant, only offered in IDLE and never while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && (state == IDLE)) begin
      if (r0_req && r1_req) begin
        if (last_gnt) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else if (r0_req) begin
        gnt0 = 1'b1;
      end else if (r1_req) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign any_gnt = gnt0 | gnt1;
  assign r0_gnt  = gnt0;
  assign r1_gnt  = gnt1;

  // Select the granted port's fields and classify the request before latching.
  always_comb begin
    cur_we     = r0_we;
    cur_funct3 = r0_funct3;
    cur_addr   = r0_addr;
    cur_wdata  = r0_wdata;
    if (gnt1) begin
      cur_we     = r1_we;
      cur_funct3 = r1_funct3;
      cur_addr   = r1_addr;
      cur_wdata  = r1_wdata;
    end
    cur_err = access_error(cur_we, cur_funct3, cur_addr);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: every grant is sequenced through ACCESS and RESP.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_gnt) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the winning request and remember who won for the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt   <= 1'b1;
      lat_port   <= 1'b0;
      lat_we     <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      lat_err    <= 1'b0;
    end else if (any_gnt) begin
      last_gnt   <= gnt1;
      lat_port   <= gnt1;
      lat_we     <= cur_we;
      lat_funct3 <= cur_funct3;
      lat_addr   <= cur_addr;
      lat_wdata  <= cur_wdata;
      lat_err    <= cur_err;
    end
  end

  // Register the memory result at the end of ACCESS; stores and errors return 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else if (state == ACCESS) begin
      resp_rdata <= (!lat_we && !lat_err) ? m_rdata : 32'h0;
      resp_err   <= lat_err;
    end
  end

  // Drive memory only during ACCESS of a legal request; quiet otherwise.
  always_comb begin
    m_read   = 1'b0;
    m_write  = 1'b0;
    m_funct3 = 3'b000;
    m_addr   = 32'h0;
    m_wdata  = 32'h0;
    if ((state == ACCESS) && !lat_err) begin
      m_read   = !lat_we;
      m_write  = lat_we;
      m_funct3 = lat_funct3;
      m_addr   = lat_addr;
      m_wdata  = lat_wdata;
    end
  end

  // Completion pulse in RESP, routed only to the port that owns the transaction.
  always_comb begin
    r0_rvalid = 1'b0;
    r0_err    = 1'b0;
    r0_rdata  = 32'h0;
    r1_rvalid = 1'b0;
    r1_err    = 1'b0;
    r1_rdata  = 32'h0;
    if (state == RESP) begin
      if (lat_port) begin
        r1_rvalid = 1'b1;
        r1_err    = resp_err;
        r1_rdata  = resp_rdata;
      end else begin
        r0_rvalid = 1'b1;
        r0_err    = resp_err;
        r0_rdata  = resp_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: scoreboard bench for dmem_arb with a behavioural memory device
// and a byte-array reference model of the RV32 load/store rules.

module tb_dmem_arb;

  localparam int MEM = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [2:0]  r0_funct3, r1_funct3;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        m_read, m_write;
  logic [2:0]  m_funct3;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic        port;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } item_t;

  typedef struct {
    logic port;
    int   cyc;
  } grant_t;

  item_t  sb[$];
  grant_t glog[$];

  logic [7:0] dev_mem [MEM];
  logic [7:0] shadow  [MEM];

  dmem_arb #(.MEM_BYTES(MEM)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_funct3(r0_funct3), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_err(r0_err),
    .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_funct3(r1_funct3), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_err(r1_err),
    .r1_rdata(r1_rdata),
    .m_read(m_read), .m_write(m_write), .m_funct3(m_funct3), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory device: combinational little-endian load with RV32 extension.
  function automatic logic [31:0] dev_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    w = {dev_mem[10'(a[9:0] + 10'd3)], dev_mem[10'(a[9:0] + 10'd2)],
         dev_mem[10'(a[9:0] + 10'd1)], dev_mem[a[9:0]]};
    case (f3)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd4:    return {24'h0, w[7:0]};
      3'd5:    return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // A non-zero idle pattern makes stores/errors that leak m_rdata visible.
  assign m_rdata = m_read ? dev_load(m_funct3, m_addr) : 32'hA5A5_5A5A;

  // Memory device: byte-lane write on the clock edge.
  always @(posedge clk) begin
    if (m_write) begin
      dev_mem[m_addr[9:0]] <= m_wdata[7:0];
      if (m_funct3[1:0] != 2'b00) dev_mem[10'(m_addr[9:0] + 10'd1)] <= m_wdata[15:8];
      if (m_funct3[1:0] == 2'b10) begin
        dev_mem[10'(m_addr[9:0] + 10'd2)] <= m_wdata[23:16];
        dev_mem[10'(m_addr[9:0] + 10'd3)] <= m_wdata[31:24];
      end
    end
  end

  // Reference model: classify, then apply the access to the shadow byte array.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int     size;
    longint v;
    size = 1 << f3[1:0];
    err  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4);
    if (longint'(addr) + longint'(size) > longint'(MEM)) err = 1'b1;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
    if ((addr % 32'(size)) != 32'd0) err = 1'b1;
`endif
    rdata = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) shadow[int'(addr) + i] = 8'(wdata >> (8 * i));
      end else begin
        v = 0;
        for (int i = 0; i < size; i++) v = v + (longint'(shadow[int'(addr) + i]) << (8 * i));
        if (f3 < 3'd4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
          v = v - (longint'(1) << (8 * size));
        rdata = 32'(v);
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present a request on one port, hold it until granted, log the expectation.
  task automatic applyStimulus(input logic port, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int    waited;
    item_t it;
    logic  g;
    @(negedge clk);
    if (port) begin
      r1_we = we; r1_funct3 = f3; r1_addr = addr; r1_wdata = wdata; r1_req = 1'b1;
    end else begin
      r0_we = we; r0_funct3 = f3; r0_addr = addr; r0_wdata = wdata; r0_req = 1'b1;
    end
    #1;
    waited = 0;
    g = port ? r1_gnt : r0_gnt;
    while (!g && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
      g = port ? r1_gnt : r0_gnt;
    end
    if (!g) begin
      checkOutput(port ? "gnt_timeout_r1" : "gnt_timeout_r0", 32'd0, 32'd1);
      if (port) r1_req = 1'b0; else r0_req = 1'b0;
      return;
    end
    it.port = port; it.we = we; it.f3 = f3; it.addr = addr; it.wdata = wdata; it.cyc = cyc;
    model(we, f3, addr, wdata, it.rdata, it.err);
    sb.push_back(it);
    glog.push_back('{port: port, cyc: cyc});
    @(posedge clk);
    #1;
    if (port) r1_req = 1'b0; else r0_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic random_port(input logic port, input int count);
    logic [31:0] addr;
    int          sel;
    for (int k = 0; k < count; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      addr = $urandom_range(0, 127);
      else if (sel < 8) addr = $urandom_range(1016, 1023);
      else              addr = $urandom;
      applyStimulus(port, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom);
    end
  endtask

  // Monitor: per-cycle memory-port expectations and rvalid scoreboard pops.
  always @(negedge clk) begin : monitor
    item_t it;
    logic  exp_rd, exp_wr;
    #2;
    if (mon_en) begin
      checkOutput("gnt_onehot", 32'(r0_gnt & r1_gnt), 32'd0);
      if (sb.size() > 0 && sb[0].cyc + 1 == cyc) begin
        exp_rd = !sb[0].err && !sb[0].we;
        exp_wr = !sb[0].err && sb[0].we;
        checkOutput("m_read", 32'(m_read), 32'(exp_rd));
        checkOutput("m_write", 32'(m_write), 32'(exp_wr));
        checkOutput("m_addr", m_addr, sb[0].err ? 32'h0 : sb[0].addr);
        checkOutput("m_funct3", 32'(m_funct3), sb[0].err ? 32'h0 : 32'(sb[0].f3));
        checkOutput("m_wdata", m_wdata, sb[0].err ? 32'h0 : sb[0].wdata);
      end else begin
        checkOutput("m_quiet", 32'({m_read, m_write}), 32'd0);
      end
      if (r0_rvalid || r1_rvalid) begin
        if (sb.size() == 0) begin
          checkOutput("rvalid_unexpected", 32'({r1_rvalid, r0_rvalid}), 32'd0);
        end else begin
          it = sb.pop_front();
          checkOutput("rv_port", 32'(r1_rvalid), 32'(it.port));
          checkOutput("rv_onehot", 32'(r0_rvalid & r1_rvalid), 32'd0);
          checkOutput("rv_latency", 32'(cyc - it.cyc), 32'd2);
          checkOutput("rv_rdata", it.port ? r1_rdata : r0_rdata, it.rdata);
          checkOutput("rv_err", 32'(it.port ? r1_err : r0_err), 32'(it.err));
          checkOutput("rv_other_quiet",
                      it.port ? (r0_rdata | 32'(r0_err)) : (r1_rdata | 32'(r1_err)), 32'd0);
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc + 2) begin
        it = sb.pop_front();
        checkOutput("rv_missing", 32'd0, 32'd1);
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset checks, directed scenarios, then randomized contention.
  initial begin : main
    logic [7:0] b;
    for (int i = 0; i < MEM; i++) begin
      b = 8'($urandom);
      dev_mem[i] <= b;
      shadow[i] = b;
    end
    rst_n = 1'b0;
    r0_req = 1'b1; r0_we = 1'b1; r0_funct3 = 3'd2; r0_addr = 32'h10; r0_wdata = 32'h1;
    r1_req = 1'b1; r1_we = 1'b0; r1_funct3 = 3'd2; r1_addr = 32'h20; r1_wdata = 32'h2;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_gnt", 32'({r0_gnt, r1_gnt}), 32'd0);
    checkOutput("reset_rvalid", 32'({r0_rvalid, r1_rvalid, r0_err, r1_err}), 32'd0);
    checkOutput("reset_rdata", r0_rdata | r1_rdata, 32'd0);
    checkOutput("reset_mem", 32'({m_read, m_write}) | m_addr | m_wdata | 32'(m_funct3), 32'd0);
    r0_req = 1'b0; r1_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    $display("[TB] round-robin with both ports loading");
    fork
      begin repeat (2) applyStimulus(1'b0, 1'b0, 3'd2, 32'h100, 32'h0); end
      begin repeat (2) applyStimulus(1'b1, 1'b0, 3'd2, 32'h104, 32'h0); end
    join
    drain();
    checkOutput("rr_count", 32'(glog.size()), 32'd4);
    if (glog.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput("rr_order", 32'(glog[i].port), 32'(i % 2));
        if (i > 0) checkOutput("rr_spacing", 32'(glog[i].cyc - glog[i-1].cyc), 32'd3);
      end
    end
    $display("[TB] store then load at 0x10");
    applyStimulus(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 3'd2, 32'h10, 32'h0);
    drain();
    $display("[TB] bounds, misalign and illegal encodings");
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h3FF, 32'h0);
    applyStimulus(1'b1, 1'b0, 3'd2, 32'h3FE, 32'h0);
    applyStimulus(1'b0, 1'b0, 3'd1, 32'h21, 32'h0);
    applyStimulus(1'b1, 1'b0, 3'd3, 32'h20, 32'h0);
    applyStimulus(1'b1, 1'b1, 3'd4, 32'h20, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, 3'd4, 32'h10, 32'h0);
    drain();
    $display("[TB] reset during a store ACCESS");
    mon_en = 1'b0;
    @(negedge clk);
    r0_we = 1'b1; r0_funct3 = 3'd2; r0_addr = 32'h40; r0_wdata = 32'hCAFE_F00D; r0_req = 1'b1;
    #1;
    checkOutput("rst_test_gnt", 32'(r0_gnt), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("rst_test_mwrite_before", 32'(m_write), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_test_mwrite_after", 32'({m_read, m_write}), 32'd0);
    checkOutput("rst_test_gnt_held", 32'(r0_gnt), 32'd0);
    repeat (2) @(negedge clk);
    r0_req = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      checkOutput("rst_test_no_rvalid", 32'({r0_rvalid, r1_rvalid, m_read, m_write}), 32'd0);
      @(negedge clk);
    end
    sb.delete();
    mon_en = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'd2, 32'h40, 32'h0);
    drain();
    $display("[TB] randomized contention");
    fork
      random_port(1'b0, 80);
      random_port(1'b1, 80);
    join
    drain();
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
